vend_sequencer: RTL and testbench

- Control FSM for the vending machine.
- Accumulates coin credit, gates purchase requests against a fixed price, and runs a req/ack handshake with the product dispenser.
- Returns change or refunds as a stream of single-nickel pulses.
- Drives the machine's 4-bit state encoding, also exported for display/debug.

---
 rtl/vend_pkg.sv | 35 +++
 rtl/vend_credit_reg.sv | 49 ++++
 rtl/vend_sequencer.sv | 137 +++++++++++++
 tb/tb_vend_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine sequencer:
// state encodings, coin codes and the coin value lookup.
package vend_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0000,
        ST_COLLECT = 4'b0001,
        ST_VEND    = 4'b0010,
        ST_CHANGE  = 4'b0011,
        ST_REFUND  = 4'b0100
    } state_e;

    typedef enum logic [1:0] {
        COIN_5   = 2'b00,
        COIN_10  = 2'b01,
        COIN_25  = 2'b10,
        COIN_100 = 2'b11
    } coin_e;

    localparam int NICKEL = 5;

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        logic [7:0] cents;
        cents = 8'd0;
        case (coin_e'(code))
            COIN_5:   cents = 8'd5;
            COIN_10:  cents = 8'd10;
            COIN_25:  cents = 8'd25;
            COIN_100: cents = 8'd100;
            default:  cents = 8'd0;
        endcase
        return cents;
    endfunction

endpackage

// File: rtl/vend_credit_reg.sv
// Credit accumulator: adds accepted coins, subtracts the price or one nickel,
// and flags whether a coin would push credit past the ceiling.
module vend_credit_reg
    import vend_pkg::*;
#(
    parameter int PRICE      = 75,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 200
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                add_en_i,
    input  logic [7:0]          add_val_i,
    input  logic                sub_price_i,
    input  logic                sub_nickel_i,
    output logic                accept_o,
    output logic                zero_o,
    output logic [CREDIT_W-1:0] credit_o
);

    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W:0]   sum;

    // One extra bit on the sum so the ceiling compare cannot overflow.
    always_comb begin
        sum      = {1'b0, credit_q} + (CREDIT_W+1)'(add_val_i);
        accept_o = (sum <= (CREDIT_W+1)'(MAX_CREDIT));
        credit_d = credit_q;
        if (add_en_i && accept_o) begin
            credit_d = sum[CREDIT_W-1:0];
        end else if (sub_price_i) begin
            credit_d = credit_q - CREDIT_W'(PRICE);
        end else if (sub_nickel_i) begin
            credit_d = credit_q - CREDIT_W'(NICKEL);
        end
    end

    always_ff @(negedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign zero_o   = (credit_q == '0);
    assign credit_o = credit_q;

endmodule

// File: rtl/vend_sequencer.sv
// Vending machine control FSM: collects coins, runs the dispenser handshake
// and pays out change or refunds one nickel per cycle.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE      = 75,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 200
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                select,
    input  logic                cancel,
    input  logic                vend_ack,
    output logic                vend_req,
    output logic                nickel_out,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic [3:0]          state,
    output logic                busy
);

    if ((PRICE % NICKEL) != 0 || PRICE > MAX_CREDIT) begin : g_bad_price
        $error("vend_sequencer: PRICE must be a multiple of 5 and not exceed MAX_CREDIT");
    end

    state_e state_q, state_d;
    logic   vend_req_q, vend_req_d;
    logic   nickel_q, nickel_d;
    logic   reject_q, reject_d;
    logic   busy_q, busy_d;
    logic   add_en, sub_price, sub_nickel, accept, zero;
    logic [7:0] add_val;

    vend_credit_reg #(
        .PRICE      (PRICE),
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_credit (
        .clk_i        (clk),
        .reset_i      (reset),
        .add_en_i     (add_en),
        .add_val_i    (add_val),
        .sub_price_i  (sub_price),
        .sub_nickel_i (sub_nickel),
        .accept_o     (accept),
        .zero_o       (zero),
        .credit_o     (credit)
    );

    always_comb begin
        state_d    = state_q;
        vend_req_d = 1'b0;
        nickel_d   = 1'b0;
        reject_d   = 1'b0;
        add_en     = 1'b0;
        sub_price  = 1'b0;
        sub_nickel = 1'b0;
        add_val    = coin_value(coin_type);
        case (state_q)
            ST_IDLE: begin
                if (coin_valid) begin
                    if (accept) begin
                        add_en  = 1'b1;
                        state_d = ST_COLLECT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (cancel) begin
                    state_d  = ST_REFUND;
                    reject_d = coin_valid;
                end else if (coin_valid) begin
                    add_en   = accept;
                    reject_d = !accept;
                end else if (select && credit >= CREDIT_W'(PRICE)) begin
                    state_d    = ST_VEND;
                    vend_req_d = 1'b1;
                end
            end
            ST_VEND: begin
                reject_d = coin_valid;
                if (vend_ack) begin
                    sub_price = 1'b1;
                    state_d   = (credit == CREDIT_W'(PRICE)) ? ST_IDLE : ST_CHANGE;
                end else begin
                    vend_req_d = 1'b1;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                reject_d = coin_valid;
                if (zero) begin
                    state_d = ST_IDLE;
                end else begin
                    sub_nickel = 1'b1;
                    nickel_d   = 1'b1;
                    if (credit == CREDIT_W'(NICKEL)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            // Corrupted encoding: give back whatever credit is held.
            default: begin
                reject_d = coin_valid;
                state_d  = zero ? ST_IDLE : ST_REFUND;
            end
        endcase
        busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE) || (state_d == ST_REFUND);
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            vend_req_q <= 1'b0;
            nickel_q   <= 1'b0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vend_req_q <= vend_req_d;
            nickel_q   <= nickel_d;
            reject_q   <= reject_d;
            busy_q     <= busy_d;
        end
    end

    assign state       = state_q;
    assign vend_req    = vend_req_q;
    assign nickel_out  = nickel_q;
    assign coin_reject = reject_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer. Flops move on the falling
// edge, so inputs are driven and outputs sampled on the rising edge.
module tb_vend_sequencer;

    logic       clk;
    logic       reset;
    logic       coinValid;
    logic [1:0] coinType;
    logic       selectIn;
    logic       cancelIn;
    logic       vendAck;
    logic       vendReq;
    logic       nickelOut;
    logic       coinReject;
    logic [7:0] credit;
    logic [3:0] state;
    logic       busy;

    int checkCount;
    int errorCount;

    vend_sequencer #(
        .PRICE      (75),
        .CREDIT_W   (8),
        .MAX_CREDIT (200)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_valid  (coinValid),
        .coin_type   (coinType),
        .select      (selectIn),
        .cancel      (cancelIn),
        .vend_ack    (vendAck),
        .vend_req    (vendReq),
        .nickel_out  (nickelOut),
        .coin_reject (coinReject),
        .credit      (credit),
        .state       (state),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input int got, input int exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs; returns at the next rising edge, after the
    // falling edge that consumed them.
    task automatic applyStimulus(input logic cv, input logic [1:0] ct,
                                 input logic sel, input logic can, input logic ack);
        coinValid = cv;
        coinType  = ct;
        selectIn  = sel;
        cancelIn  = can;
        vendAck   = ack;
        @(posedge clk);
    endtask

    // Idle until the payout finishes, counting nickels and watching for gaps
    // or a stray vend request. Bounded so a stuck FSM still reaches the summary.
    task automatic runOut(input string tag, input int expNickels);
        int  pulses;
        bit  started;
        bit  gap;
        bit  sawReq;
        bit  done;
        pulses  = 0;
        started = 0;
        gap     = 0;
        sawReq  = 0;
        done    = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
            if (vendReq) sawReq = 1;
            if (nickelOut) begin
                pulses++;
                started = 1;
            end else if (started && state != 4'd0) begin
                gap = 1;
            end
            if (state == 4'd0 && !nickelOut) done = 1;
        end
        checkOutput({tag, " nickels"}, pulses, expNickels);
        checkOutput({tag, " gap"}, int'(gap), 0);
        checkOutput({tag, " vend_req"}, int'(sawReq), 0);
        checkOutput({tag, " end state"}, int'(state), 0);
        checkOutput({tag, " end credit"}, int'(credit), 0);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset      = 1'b1;
        coinValid  = 1'b0;
        coinType   = 2'b00;
        selectIn   = 1'b0;
        cancelIn   = 1'b0;
        vendAck    = 1'b0;
        #1;
        checkOutput("reset state", int'(state), 0);
        checkOutput("reset credit", int'(credit), 0);
        checkOutput("reset vend_req", int'(vendReq), 0);
        checkOutput("reset nickel", int'(nickelOut), 0);
        checkOutput("reset reject", int'(coinReject), 0);
        checkOutput("reset busy", int'(busy), 0);
        @(posedge clk);
        @(posedge clk);
        reset = 1'b0;
        @(posedge clk);

        // Three quarters with select held: coins win, vend starts afterwards.
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        checkOutput("t1 credit 25", int'(credit), 25);
        checkOutput("t1 state collect", int'(state), 1);
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        checkOutput("t1 credit 75", int'(credit), 75);
        checkOutput("t1 no req yet", int'(vendReq), 0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("t1 state vend", int'(state), 2);
        checkOutput("t1 vend_req", int'(vendReq), 1);
        checkOutput("t1 busy", int'(busy), 1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("t1 req held", int'(vendReq), 1);
        checkOutput("t1 cancel ignored", int'(state), 2);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("t1 req drop", int'(vendReq), 0);
        checkOutput("t1 credit 0", int'(credit), 0);
        checkOutput("t1 state idle", int'(state), 0);
        checkOutput("t1 nickel", int'(nickelOut), 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("t1 nickel after", int'(nickelOut), 0);
        checkOutput("t1 busy after", int'(busy), 0);

        // Dollar coin buys one item and gets 25c back as five nickels.
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        checkOutput("t2 credit 100", int'(credit), 100);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("t2 state vend", int'(state), 2);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("t2 credit 25", int'(credit), 25);
        checkOutput("t2 state change", int'(state), 3);
        runOut("t2", 5);

        // Short credit: select ignored, stray ack ignored, cancel refunds.
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("t3 state collect", int'(state), 1);
        checkOutput("t3 credit 20", int'(credit), 20);
        checkOutput("t3 no req", int'(vendReq), 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("t3 state refund", int'(state), 4);
        checkOutput("t3 busy", int'(busy), 1);
        runOut("t3", 4);

        // Credit ceiling: 150+100 rejected, 200 exactly accepted, 205 rejected.
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        checkOutput("t4 credit 150", int'(credit), 150);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        checkOutput("t4 reject 100", int'(coinReject), 1);
        checkOutput("t4 credit kept", int'(credit), 150);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("t4 reject pulse", int'(coinReject), 0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        checkOutput("t4 credit 200", int'(credit), 200);
        checkOutput("t4 accept at max", int'(coinReject), 0);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("t4 reject 5c", int'(coinReject), 1);
        checkOutput("t4 credit max", int'(credit), 200);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        checkOutput("t4 reject in vend", int'(coinReject), 1);
        checkOutput("t4 credit in vend", int'(credit), 200);
        checkOutput("t4 state vend", int'(state), 2);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("t4 credit 125", int'(credit), 125);
        runOut("t4", 25);

        // Cancel beats select and rejects a simultaneous coin.
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
        checkOutput("t5 state refund", int'(state), 4);
        checkOutput("t5 reject", int'(coinReject), 1);
        checkOutput("t5 credit 100", int'(credit), 100);
        checkOutput("t5 no req", int'(vendReq), 0);
        runOut("t5", 20);

        // Asynchronous reset mid-collect clears state without a clock edge.
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        coinValid = 1'b0;
        checkOutput("t6 credit 50", int'(credit), 50);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6 async state", int'(state), 0);
        checkOutput("t6 async credit", int'(credit), 0);
        checkOutput("t6 async busy", int'(busy), 0);
        checkOutput("t6 async reject", int'(coinReject), 0);
        #1 reset = 1'b0;
        @(posedge clk);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        checkOutput("t6 credit 10", int'(credit), 10);
        checkOutput("t6 state collect", int'(state), 1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        runOut("t6", 2);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
